serial_paralelo: RTL

Receive-side serial-to-parallel converter for the PHY link: sits directly downstream of the transmit serializer, receiving its MSB-first bit stream on `clk_32f`. It hunts for the idle comma character, locks byte alignment after a run of aligned commas, and presents each received data byte on an 8-bit bus. Each byte is held for one byte period so a byte-rate (`clk_4f`) consumer can sample it. Comma bytes are treated as idle: they are never forwarded as data.

---
 rtl/serial_paralelo.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/serial_paralelo.sv
// serial_paralelo -- receive-side serial-to-parallel converter.
//
// Takes the MSB-first bit stream from the link serializer (one bit per
// clk_32f cycle), hunts for the idle comma, locks byte alignment after
// BC_COUNT aligned commas and then presents each non-comma byte on
// out_paralelo for one byte period (8 bit clocks). Comma bytes are idle
// and are never forwarded.
//
// Parameters:
//   COMMA     idle / alignment character (default 8'hBC)
//   BC_COUNT  aligned commas needed to declare the link active (1..15)
// Ports:
//   clk_32f       bit-rate clock, all state on posedge
//   reset         asynchronous, active-high
//   in_serial     serial line, MSB of each byte first
//   out_paralelo  last received data byte (registered)
//   valid_out     out_paralelo holds a data byte of the current byte period
//   active        byte alignment locked
// Optional build macro:
//   SP_RESYNC_EN  in ACTIVE, a comma seen off the byte boundary right after
//                 an idle boundary drops the lock and restarts the hunt.
//                 Without it ACTIVE is sticky until reset.
module serial_paralelo #(
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter int unsigned BC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       in_serial,
  output logic [7:0] out_paralelo,
  output logic       valid_out,
  output logic       active
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] BC_MAX = 4'(BC_COUNT);

  state_t     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic [7:0] out_q, out_d;
  logic       valid_q, valid_d;
  logic       active_q, active_d;
`ifdef SP_RESYNC_EN
  // Remembers whether the last boundary byte in ACTIVE was idle.
  logic       last_comma_q, last_comma_d;
`endif

  logic is_comma, boundary;

  // The registered shreg holds a complete byte when bit_cnt is 0.
  assign is_comma = (shreg_q == COMMA);
  assign boundary = (bit_cnt_q == 3'd0);

  always_comb begin
    state_d   = state_q;
    shreg_d   = {shreg_q[6:0], in_serial};
    bit_cnt_d = bit_cnt_q;
    bc_cnt_d  = bc_cnt_q;
    out_d     = out_q;
    valid_d   = valid_q;
    active_d  = active_q;
`ifdef SP_RESYNC_EN
    last_comma_d = last_comma_q;
`endif
    case (state_q)
      HUNT: begin
        // The comma just completed; the next byte starts with the bit
        // shifted at this edge, so the counter is already one bit in.
        if (is_comma) begin
          bit_cnt_d = 3'd1;
          bc_cnt_d  = 4'd1;
          if (BC_COUNT == 1) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
`ifdef SP_RESYNC_EN
            last_comma_d = 1'b1;
`endif
          end else begin
            state_d = SYNC;
          end
        end
      end
      SYNC: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            if (bc_cnt_q + 4'd1 >= BC_MAX) begin
              bc_cnt_d = BC_MAX;
              state_d  = ACTIVE;
              active_d = 1'b1;
`ifdef SP_RESYNC_EN
              last_comma_d = 1'b1;
`endif
            end else begin
              bc_cnt_d = bc_cnt_q + 4'd1;
            end
          end else begin
            state_d  = HUNT;
            bc_cnt_d = 4'd0;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (!is_comma) begin
            out_d   = shreg_q;
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
`ifdef SP_RESYNC_EN
          last_comma_d = is_comma;
        end else if (last_comma_q && is_comma) begin
          // Comma off the boundary while idle: alignment slipped.
          state_d   = HUNT;
          active_d  = 1'b0;
          valid_d   = 1'b0;
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd0;
`endif
        end
      end
      default: begin
        state_d  = HUNT;
        active_d = 1'b0;
        valid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q   <= HUNT;
      shreg_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 4'd0;
      out_q     <= 8'h00;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
`ifdef SP_RESYNC_EN
      last_comma_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
`ifdef SP_RESYNC_EN
      last_comma_q <= last_comma_d;
`endif
    end
  end

  assign out_paralelo = out_q;
  assign valid_out    = valid_q;
  assign active       = active_q;

endmodule
